line_memory: RTL and testbench

Line-granularity backing store that answers the data cache's miss and write-back traffic. It accepts one line-wide read or write request at a time over the `is_input_valid` / `mem_ready` handshake and completes it after a fixed multi-cycle latency. Read data is returned with a one-cycle `is_output_valid` pulse. It sits directly below the data cache and is the only model of main memory on the data side.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/line_memory_if.sv | 26 ++
 rtl/latency_timer.sv | 28 ++
 rtl/line_memory.sv | 111 +++++++++++
 tb/tb_line_memory.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the line-granularity memory model: state encoding,
// default geometry/latency constants and the width helper macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DEFAULT_BLOCK_SIZE = 16;
    localparam int DEFAULT_NUM_LINES  = 16384;
    localparam int DEFAULT_LATENCY    = 50;

endpackage

// File: rtl/line_memory_if.sv
// Request/response bundle between the data cache (master) and line_memory (slave).
// Handshake: a request transfers on a rising clk edge where is_input_valid and
// mem_ready are both high and exactly one of mem_read/mem_write is set; read data
// is qualified by a single-cycle is_output_valid pulse with no backpressure.
interface line_memory_if #(
    parameter int BLOCK_SIZE = 16
);
    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_SIZE*8-1:0] din;
    logic                    is_output_valid;
    logic [BLOCK_SIZE*8-1:0] dout;
    logic                    mem_ready;

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  is_output_valid, dout, mem_ready
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output is_output_valid, dout, mem_ready
    );
endinterface

// File: rtl/latency_timer.sv
// Loadable down-counter: stops at zero, done flags the last busy cycle
// (count of 1) or a load with zero, which means "finish immediately".
module latency_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         done,
    output logic [W-1:0] count
);

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = load ? (value == '0) : (count == W'(1));

endmodule

// File: rtl/line_memory.sv
// Line-wide backing store below the data cache. One request in flight at a
// time; each completes LATENCY cycles after acceptance in a single RESP cycle.
module line_memory
    import mem_if_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int NUM_LINES  = DEFAULT_NUM_LINES,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic       clk,
    input  logic       reset,
    line_memory_if.slave bus,
    output mem_state_t state
);

    localparam int DATA_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = `CLOG2(NUM_LINES);
    localparam int CNT_W  = `CLOG2(LATENCY + 1);

    // Array is zero at power-up and deliberately untouched by reset.
    logic [DATA_W-1:0] mem [NUM_LINES] = '{default: '0};

    mem_state_t        state_d;
    logic              accept;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] din_q;
    logic              read_q;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_read;
    logic              timer_done;
    logic [CNT_W-1:0]  timer_count;
    logic              out_valid_q;
    logic [DATA_W-1:0] dout_q;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[31:IDX_W];

    assign accept = (state == IDLE) && bus.is_input_valid && (bus.mem_read ^ bus.mem_write);

    // On the accepting edge the request is still on the pins; afterwards use the latched copy.
    assign cur_idx  = accept ? bus.addr[IDX_W-1:0] : idx_q;
    assign cur_read = accept ? bus.mem_read : read_q;

    latency_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (state == BUSY),
        .value (CNT_W'(LATENCY - 1)),
        .done  (timer_done),
        .count (timer_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; LATENCY==1 loads zero and jumps directly to RESP.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = timer_done ? RESP : BUSY;
            BUSY: if (timer_done) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the accepted request so later pin activity cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            din_q  <= '0;
            read_q <= 1'b0;
        end else if (accept) begin
            idx_q  <= bus.addr[IDX_W-1:0];
            din_q  <= bus.din;
            read_q <= bus.mem_read;
        end
    end

    // Registered read response, loaded on the edge that enters RESP; dout holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            out_valid_q <= (state_d == RESP) && cur_read;
            if ((state_d == RESP) && cur_read) begin
                dout_q <= mem[cur_idx];
            end
        end
    end

    // Write commit at the edge ending RESP; a reset before that edge drops it.
    always_ff @(posedge clk) begin
        if ((state == RESP) && !read_q) begin
            mem[idx_q] <= din_q;
        end
    end

    assign bus.mem_ready       = (state == IDLE);
    assign bus.is_output_valid = out_valid_q;
    assign bus.dout            = dout_q;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: requests push expected read data and response
// cycle into queues; a negedge monitor pops and compares on every response.
module tb_line_memory;
    import mem_if_pkg::*;

    localparam int LAT = 50;
    localparam int BS  = 16;
    localparam int W   = BS * 8;

    logic       clk;
    logic       reset;
    mem_state_t state;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];

    line_memory_if #(.BLOCK_SIZE(BS)) bus ();

    line_memory #(.BLOCK_SIZE(BS), .NUM_LINES(16384), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && bus.is_output_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d dout=%h", cyc, bus.dout);
            end else begin
                logic [W-1:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (bus.dout !== e || cyc != ec) begin
                    errors++;
                    $display("FAIL read_resp got dout=%h cyc=%0d expected dout=%h cyc=%0d",
                             bus.dout, cyc, e, ec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic clear_pins();
        bus.is_input_valid = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
    endtask

    // Issue one request once mem_ready is seen; returns the acceptance cycle T.
    task automatic issue(input bit is_read, input logic [31:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] exp_d, output int t_acc);
        int waited = 0;
        @(negedge clk);
        while (!bus.mem_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.mem_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout cyc=%0d mem_ready=0 expected 1", cyc);
        end
        bus.is_input_valid = 1'b1;
        bus.mem_read       = is_read;
        bus.mem_write      = !is_read;
        bus.addr           = a;
        bus.din            = d;
        t_acc              = cyc;
        if (is_read) begin
            exp_q.push_back(exp_d);
            exp_cyc_q.push_back(t_acc + LAT);
        end
        @(posedge clk);
        #1 clear_pins();
    endtask

    // Stimulus.
    initial begin
        int t_w, t_r, bad;
        logic [W-1:0] val_a, val_b, val_c, val_d;
        val_a = 128'hDEADBEEF_00112233_44556677_8899AABB;
        val_b = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
        val_c = 128'h0F0F0F0F_F0F0F0F0_CAFEBABE_12345678;
        val_d = 128'h11112222_33334444_55556666_77778888;

        reset = 1'b0;
        clear_pins();
        bus.addr = '0;
        bus.din  = '0;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_ready", W'(bus.mem_ready), W'(1));
        check("rst_valid", W'(bus.is_output_valid), W'(0));
        check("rst_dout", bus.dout, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Write then read addr 5 with the ready window checked.
        issue(1'b0, 32'd5, val_a, '0, t_w);
        bad = 0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (bus.mem_ready !== 1'b0) bad++;
        end
        check("ready_low_window", W'(bad), W'(0));
        issue(1'b1, 32'd5, '0, val_a, t_r);
        check("b2b_accept_cycle", W'(t_r - t_w), W'(LAT + 1));

        // Illegal (both) then idle (neither) requests: no acceptance.
        @(negedge clk);
        while (!bus.mem_ready) @(negedge clk);
        bus.is_input_valid = 1'b1;
        bus.mem_read       = 1'b1;
        bus.mem_write      = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.mem_ready !== 1'b1) bad++;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mem_ready !== 1'b1) bad++;
        end
        check("illegal_ready", W'(bad), W'(0));
        clear_pins();

        // Input isolation: pins churn while a read of addr 7 is in flight.
        issue(1'b0, 32'd7, val_b, '0, t_w);
        issue(1'b0, 32'd9, val_c, '0, t_w);
        issue(1'b1, 32'd7, '0, val_b, t_r);
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            bus.is_input_valid = 1'b1;
            bus.mem_write      = 1'b1;
            bus.mem_read       = 1'b0;
            bus.addr           = 32'd9;
            bus.din            = (i % 2 == 0) ? val_a : ~val_a;
        end
        @(negedge clk) clear_pins();
        issue(1'b1, 32'd9, '0, val_c, t_r);

        // Index aliasing: upper address bits are ignored.
        issue(1'b0, 32'h0001_4003, val_d, '0, t_w);
        issue(1'b1, 32'd3, '0, val_d, t_r);

        // Reset during a write: nothing committed, outputs clear immediately.
        issue(1'b1, 32'd5, '0, val_a, t_r);
        issue(1'b0, 32'd2, 128'h1, '0, t_w);
        repeat (19) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_ready", W'(bus.mem_ready), W'(1));
        check("midrst_valid", W'(bus.is_output_valid), W'(0));
        check("midrst_dout", bus.dout, '0);
        check("midrst_cycle", W'(cyc - t_w), W'(20));
        @(negedge clk) reset = 1'b0;
        issue(1'b1, 32'd2, '0, '0, t_r);

        // Drain outstanding responses.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
